// File: rtl/supernova_pkg.sv
// Shared types for the supernova core slice: reservation-station entry
// payload, ROB index width and the FPU issue-controller state encoding.
package supernova_pkg;

  localparam int unsigned ROB_IDX_WIDTH  = 6;
  localparam int unsigned PREG_IDX_WIDTH = 7;
  localparam int unsigned FPU_OP_WIDTH   = 5;
  localparam int unsigned FFLAGS_WIDTH   = 5;

  // Operation as issued from a reservation station
  typedef struct packed {
    logic [ROB_IDX_WIDTH-1:0]  rob_idx;
    logic [FPU_OP_WIDTH-1:0]   fpu_op;
    logic [2:0]                rm;
    logic [1:0]                fmt;
    logic [PREG_IDX_WIDTH-1:0] rs1;
    logic [PREG_IDX_WIDTH-1:0] rs2;
    logic [PREG_IDX_WIDTH-1:0] rs3;
    logic [PREG_IDX_WIDTH-1:0] rd;
  } rs_entry_t;

  typedef enum logic [1:0] {
    FPU_IDLE  = 2'd0,
    FPU_ISSUE = 2'd1,
    FPU_WAIT  = 2'd2,
    FPU_DRAIN = 2'd3
  } fpu_ctrl_state_t;

endpackage

// File: rtl/supernova_rr_arbiter.sv
// Round-robin arbiter for shared units.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req        : per-requester request
//   advance    : grant consumed this cycle; rotate priority past the winner
//   gnt        : one-hot grant (combinational)
//   rr_ptr     : current highest-priority requester
module supernova_rr_arbiter #(
  parameter  int unsigned N     = 2,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] rr_ptr
);

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Search from rr_ptr upward, wrapping modulo N
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Priority moves to the requester just after the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (advance && found) begin
      rr_ptr_q <= (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/supernova_fpu_issue_ctrl.sv
// Issue controller for the shared multi-cycle FPU. Arbitrates the issue
// ports round-robin, keeps one op in flight, runs the FPU request/writeback
// handshake, kills writebacks of flushed ops, aborts hung ops via a
// watchdog, and owns the sticky fflags accumulator.
// Ports:
//   req_valid_in/req_entry_in/req_ready_out : issue ports (ready = one-hot grant, IDLE only)
//   fpu_req_*                               : request to the FPU
//   fpu_wb_*                                : FPU writeback (valid pulse, ROB index, flags)
//   flush_in / wb_kill_out                  : pipeline flush, kill of a flushed op's writeback
//   fflags_we_in/fflags_wdata_in/fflags_out : CSR access to sticky flags
//   busy_out, wdog_err_out                  : status, watchdog abort pulse
module supernova_fpu_issue_ctrl
  import supernova_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  rs_entry_t                req_entry_in [NUM_REQ],
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic                     fpu_req_valid_out,
  output rs_entry_t                fpu_req_entry_out,
  input  logic                     fpu_req_ready_in,
  input  logic                     fpu_wb_valid_in,
  input  logic [ROB_IDX_WIDTH-1:0] fpu_wb_rob_idx_in,
  input  logic [FFLAGS_WIDTH-1:0]  fpu_wb_fflags_in,
  input  logic                     flush_in,
  output logic                     wb_kill_out,
  input  logic                     fflags_we_in,
  input  logic [FFLAGS_WIDTH-1:0]  fflags_wdata_in,
  output logic [FFLAGS_WIDTH-1:0]  fflags_out,
  output logic                     busy_out,
  output logic                     wdog_err_out
);

  localparam int unsigned RR_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WDOG_W   = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  fpu_ctrl_state_t            state_q, state_d;
  rs_entry_t                  op_q;
  rs_entry_t                  sel_entry;
  logic [ROB_IDX_WIDTH-1:0]   tag_q;
  logic [FFLAGS_WIDTH-1:0]    fflags_q, fflags_d;
  logic [WDOG_W-1:0]          wdog_cnt_q;
  logic                       wdog_err_q;

  logic [NUM_REQ-1:0]         arb_req;
  logic [NUM_REQ-1:0]         gnt;
  logic [RR_PTR_W-1:0]        rr_ptr;
  logic                       grant_any;
  logic                       tag_match_c;
  logic                       wdog_expired_c;
  logic                       capture_c;
  logic                       accum_c;
  logic                       wb_kill_c;
  logic                       wdog_fire_c;
  logic                       wdog_clr_c;

  // Ports are only arbitrated while idle, so ready is zero elsewhere
  assign arb_req   = (state_q == FPU_IDLE) ? req_valid_in : '0;
  assign grant_any = |gnt;

  supernova_rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (grant_any),
    .gnt     (gnt),
    .rr_ptr  (rr_ptr)
  );

  // Entry of the granted port
  always_comb begin
    sel_entry = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_entry = req_entry_in[i];
    end
  end

  assign tag_match_c    = fpu_wb_valid_in && (fpu_wb_rob_idx_in == tag_q);
  assign wdog_expired_c = ((state_q == FPU_WAIT) || (state_q == FPU_DRAIN)) &&
                          (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

  // Next state; a matching writeback wins over the watchdog, flush wins over the handshake
  always_comb begin
    state_d     = state_q;
    capture_c   = 1'b0;
    accum_c     = 1'b0;
    wb_kill_c   = 1'b0;
    wdog_fire_c = 1'b0;
    wdog_clr_c  = 1'b0;
    case (state_q)
      FPU_IDLE: begin
        if (grant_any) begin
          capture_c = 1'b1;
          state_d   = FPU_ISSUE;
        end
      end
      FPU_ISSUE: begin
        if (flush_in) begin
          state_d = FPU_IDLE;
        end else if (fpu_req_ready_in) begin
          wdog_clr_c = 1'b1;
          state_d    = FPU_WAIT;
        end
      end
      FPU_WAIT: begin
        if (tag_match_c && flush_in) begin
          wb_kill_c = 1'b1;
          state_d   = FPU_IDLE;
        end else if (tag_match_c) begin
          accum_c = 1'b1;
          state_d = FPU_IDLE;
        end else if (wdog_expired_c) begin
          wdog_fire_c = 1'b1;
          state_d     = FPU_IDLE;
        end else if (flush_in) begin
          state_d = FPU_DRAIN;
        end
      end
      FPU_DRAIN: begin
        if (tag_match_c) begin
          wb_kill_c = 1'b1;
          state_d   = FPU_IDLE;
        end else if (wdog_expired_c) begin
          wdog_fire_c = 1'b1;
          state_d     = FPU_IDLE;
        end
      end
      default: state_d = FPU_IDLE;
    endcase
  end

  // CSR write and accumulation merge in the same cycle
  assign fflags_d = (fflags_we_in ? fflags_wdata_in : fflags_q) |
                    (accum_c ? fpu_wb_fflags_in : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FPU_IDLE;
    else        state_q <= state_d;
  end

  // Op register and its ROB tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      tag_q <= '0;
    end else if (capture_c) begin
      op_q  <= sel_entry;
      tag_q <= sel_entry.rob_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fflags_q <= '0;
    else        fflags_q <= fflags_d;
  end

  // Watchdog runs through WAIT and DRAIN, restarts at the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
    end else if (wdog_clr_c || (state_q == FPU_IDLE) || (state_q == FPU_ISSUE)) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_err_q <= 1'b0;
    else        wdog_err_q <= wdog_fire_c;
  end

  assign req_ready_out     = gnt;
  assign fpu_req_valid_out = (state_q == FPU_ISSUE);
  assign fpu_req_entry_out = op_q;
  assign wb_kill_out       = wb_kill_c;
  assign fflags_out        = fflags_q;
  assign busy_out          = (state_q != FPU_IDLE);
  assign wdog_err_out      = wdog_err_q;

  // Priority pointer must always name a real port; grants are one-hot
  a_rr_ptr_range : assert property (@(posedge clk) disable iff (!rst_n)
    (32'(rr_ptr) < NUM_REQ));
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready_out));

endmodule

// File: tb/tb_supernova_fpu_issue_ctrl.sv
// Self-checking bench for supernova_fpu_issue_ctrl: transaction-level model
// (round-robin winner by modular search, sticky flags by OR) against the DUT.
module tb_supernova_fpu_issue_ctrl;
  import supernova_pkg::*;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned WDOG_CYCLES = 8;

  // Op scenarios
  localparam int M_NORMAL      = 0;
  localparam int M_FLUSH_ISSUE = 1;
  localparam int M_FLUSH_WAIT  = 2;
  localparam int M_FLUSH_SAME  = 3;
  localparam int M_WDOG_WAIT   = 4;
  localparam int M_WDOG_DRAIN  = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid_in;
  rs_entry_t                req_entry_in [NUM_REQ];
  logic [NUM_REQ-1:0]       req_ready_out;
  logic                     fpu_req_valid_out;
  rs_entry_t                fpu_req_entry_out;
  logic                     fpu_req_ready_in;
  logic                     fpu_wb_valid_in;
  logic [ROB_IDX_WIDTH-1:0] fpu_wb_rob_idx_in;
  logic [4:0]               fpu_wb_fflags_in;
  logic                     flush_in;
  logic                     wb_kill_out;
  logic                     fflags_we_in;
  logic [4:0]               fflags_wdata_in;
  logic [4:0]               fflags_out;
  logic                     busy_out;
  logic                     wdog_err_out;

  supernova_fpu_issue_ctrl #(
    .NUM_REQ     (NUM_REQ),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_in      (req_valid_in),
    .req_entry_in      (req_entry_in),
    .req_ready_out     (req_ready_out),
    .fpu_req_valid_out (fpu_req_valid_out),
    .fpu_req_entry_out (fpu_req_entry_out),
    .fpu_req_ready_in  (fpu_req_ready_in),
    .fpu_wb_valid_in   (fpu_wb_valid_in),
    .fpu_wb_rob_idx_in (fpu_wb_rob_idx_in),
    .fpu_wb_fflags_in  (fpu_wb_fflags_in),
    .flush_in          (flush_in),
    .wb_kill_out       (wb_kill_out),
    .fflags_we_in      (fflags_we_in),
    .fflags_wdata_in   (fflags_wdata_in),
    .fflags_out        (fflags_out),
    .busy_out          (busy_out),
    .wdog_err_out      (wdog_err_out)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         m_ptr       = 0;
  logic [4:0] m_fflags    = '0;
  bit         csr_at_wb   = 1'b0;
  logic [4:0] csr_wdata_at_wb = '0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_in      = '0;
    fpu_req_ready_in  = 1'b0;
    fpu_wb_valid_in   = 1'b0;
    fpu_wb_rob_idx_in = '0;
    fpu_wb_fflags_in  = '0;
    flush_in          = 1'b0;
    fflags_we_in      = 1'b0;
    fflags_wdata_in   = '0;
    for (int p = 0; p < int'(NUM_REQ); p++) req_entry_in[p] = '0;
  endtask

  function automatic rs_entry_t rand_entry();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return rs_entry_t'(r[$bits(rs_entry_t)-1:0]);
  endfunction

  // One full operation from grant to completion/kill/abort, checked every cycle
  task automatic do_op(input logic [NUM_REQ-1:0] valids, input int rob_force,
                       input int rdy_delay, input int wb_delay, input logic [4:0] flags,
                       input int mode, input bit distract, input bit idle_flush);
    int                       win;
    int                       p;
    int                       n_wait;
    bit                       killed;
    bit                       last;
    logic [NUM_REQ-1:0]       exp_gnt;
    logic [ROB_IDX_WIDTH-1:0] tag;
    rs_entry_t                exp_entry;

    vectors++;
    if (fflags_out !== m_fflags) begin
      miscompares++;
      $display("FAIL fflags_idle: got %b want %b", fflags_out, m_fflags);
    end
    vectors++;
    if (busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_idle: got %b want 0", busy_out);
    end

    for (int q = 0; q < int'(NUM_REQ); q++) req_entry_in[q] = rand_entry();
    win = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      p = (m_ptr + k) % int'(NUM_REQ);
      if (valids[p]) win = p;
    end
    if (rob_force >= 0) req_entry_in[win].rob_idx = ROB_IDX_WIDTH'(rob_force);
    exp_entry = req_entry_in[win];
    tag       = exp_entry.rob_idx;
    exp_gnt   = '0;
    exp_gnt[win] = 1'b1;

    req_valid_in = valids;
    flush_in     = idle_flush;
    @(negedge clk);
    vectors++;
    if (req_ready_out !== exp_gnt) begin
      miscompares++;
      $display("FAIL grant: got %b want %b", req_ready_out, exp_gnt);
    end
    m_ptr = (win + 1) % int'(NUM_REQ);
    next_cycle();
    flush_in = 1'b0;

    // ISSUE: request held stable until handshake or flush
    for (int i = 0; i <= rdy_delay; i++) begin
      req_valid_in = NUM_REQ'($urandom());
      for (int q = 0; q < int'(NUM_REQ); q++) req_entry_in[q] = rand_entry();
      fpu_req_ready_in = (i == rdy_delay);
      flush_in         = (mode == M_FLUSH_ISSUE) && (i == rdy_delay);
      @(negedge clk);
      vectors++;
      if (fpu_req_valid_out !== 1'b1 || fpu_req_entry_out !== exp_entry) begin
        miscompares++;
        $display("FAIL issue_req: valid %b entry %h want 1 entry %h",
                 fpu_req_valid_out, fpu_req_entry_out, exp_entry);
      end
      vectors++;
      if (req_ready_out !== '0) begin
        miscompares++;
        $display("FAIL ready_not_idle: got %b want 0", req_ready_out);
      end
      next_cycle();
    end
    fpu_req_ready_in = 1'b0;
    flush_in         = 1'b0;

    if (mode != M_FLUSH_ISSUE) begin
      killed = (mode == M_FLUSH_WAIT) || (mode == M_FLUSH_SAME);
      n_wait = (mode >= M_WDOG_WAIT) ? int'(WDOG_CYCLES) : wb_delay + 1;
      for (int j = 0; j < n_wait; j++) begin
        last              = (mode < M_WDOG_WAIT) && (j == wb_delay);
        req_valid_in      = NUM_REQ'($urandom());
        fpu_wb_valid_in   = 1'b0;
        fpu_wb_rob_idx_in = ROB_IDX_WIDTH'($urandom());
        fpu_wb_fflags_in  = 5'($urandom());
        flush_in          = 1'b0;
        fflags_we_in      = 1'b0;
        if (last) begin
          fpu_wb_valid_in   = 1'b1;
          fpu_wb_rob_idx_in = tag;
          fpu_wb_fflags_in  = flags;
          flush_in          = (mode == M_FLUSH_SAME) || (mode == M_FLUSH_WAIT && wb_delay == 0);
          fflags_we_in      = csr_at_wb;
          fflags_wdata_in   = csr_wdata_at_wb;
        end else begin
          if (distract && j == 0) begin
            fpu_wb_valid_in   = 1'b1;
            fpu_wb_rob_idx_in = tag + ROB_IDX_WIDTH'(1);
          end
          if (mode == M_FLUSH_WAIT && j == 0) flush_in = 1'b1;
          if (mode == M_WDOG_DRAIN && j == 2) flush_in = 1'b1;
        end
        @(negedge clk);
        vectors++;
        if (wb_kill_out !== (last && killed)) begin
          miscompares++;
          $display("FAIL wb_kill: cycle %0d got %b want %b", j, wb_kill_out, last && killed);
        end
        vectors++;
        if (fpu_req_valid_out !== 1'b0 || req_ready_out !== '0 || busy_out !== 1'b1 ||
            wdog_err_out !== 1'b0) begin
          miscompares++;
          $display("FAIL wait_status: vld %b rdy %b busy %b wdog %b want 0 0 1 0",
                   fpu_req_valid_out, req_ready_out, busy_out, wdog_err_out);
        end
        next_cycle();
      end
      if (mode < M_WDOG_WAIT) begin
        if (csr_at_wb) m_fflags = csr_wdata_at_wb | (killed ? 5'b0 : flags);
        else if (!killed) m_fflags = m_fflags | flags;
      end
    end
    idle_inputs();
    csr_at_wb = 1'b0;

    // Watchdog abort: one-cycle pulse as the controller lands in IDLE
    if (mode >= M_WDOG_WAIT) begin
      @(negedge clk);
      vectors++;
      if (wdog_err_out !== 1'b1 || busy_out !== 1'b0) begin
        miscompares++;
        $display("FAIL wdog_pulse: wdog %b busy %b want 1 0", wdog_err_out, busy_out);
      end
      next_cycle();
      @(negedge clk);
      vectors++;
      if (wdog_err_out !== 1'b0) begin
        miscompares++;
        $display("FAIL wdog_single: got %b want 0", wdog_err_out);
      end
      next_cycle();
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready_out, fpu_req_valid_out, fpu_req_entry_out, wb_kill_out, fflags_out,
         busy_out, wdog_err_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy %b vld %b entry %h kill %b ff %b busy %b wdog %b want all 0",
               req_ready_out, fpu_req_valid_out, fpu_req_entry_out, wb_kill_out, fflags_out,
               busy_out, wdog_err_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    m_ptr    = 0;
    m_fflags = '0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_single_op();
    do_op(2'b01, 5, 0, 0, 5'b00001, M_NORMAL, 1'b0, 1'b0);
    vectors++;
    if (fflags_out !== 5'b00001) begin
      miscompares++;
      $display("FAIL single_fflags: got %b want 00001", fflags_out);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int k = 0; k < 4; k++) do_op(2'b11, -1, k % 2, 1, 5'b0, M_NORMAL, 1'b0, 1'b0);
    // An empty cycle must not move the pointer
    @(negedge clk);
    vectors++;
    if (req_ready_out !== '0) begin
      miscompares++;
      $display("FAIL no_req_grant: got %b want 0", req_ready_out);
    end
    next_cycle();
    do_op(2'b11, -1, 0, 0, 5'b0, M_NORMAL, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    do_op(2'b10, -1, 1, 3, 5'b10000, M_FLUSH_WAIT, 1'b1, 1'b0);
    do_op(2'b11, -1, 0, 2, 5'b01000, M_FLUSH_SAME, 1'b0, 1'b0);
    do_op(2'b01, -1, 2, 0, 5'b00010, M_FLUSH_ISSUE, 1'b0, 1'b0);
    do_op(2'b11, -1, 0, 2, 5'b00100, M_NORMAL, 1'b1, 1'b0);
  endtask

  task automatic test_csr_write();
    logic [4:0] w;
    w = 5'($urandom());
    fflags_we_in    = 1'b1;
    fflags_wdata_in = w;
    next_cycle();
    idle_inputs();
    m_fflags = w;
    vectors++;
    if (fflags_out !== w) begin
      miscompares++;
      $display("FAIL csr_write: got %b want %b", fflags_out, w);
    end
    csr_at_wb       = 1'b1;
    csr_wdata_at_wb = 5'b00100;
    do_op(2'b01, -1, 0, 1, 5'b00001, M_NORMAL, 1'b0, 1'b0);
    vectors++;
    if (fflags_out !== 5'b00101) begin
      miscompares++;
      $display("FAIL csr_accum: got %b want 00101", fflags_out);
    end
  endtask

  task automatic test_watchdog();
    do_op(2'b01, -1, 0, 0, 5'b11111, M_WDOG_WAIT, 1'b1, 1'b0);
    do_op(2'b10, -1, 1, 0, 5'b11111, M_WDOG_DRAIN, 1'b0, 1'b0);
    do_op(2'b11, -1, 0, 1, 5'b00010, M_NORMAL, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    req_valid_in    = 2'b10;
    req_entry_in[1] = rand_entry();
    next_cycle();
    req_valid_in     = '0;
    fpu_req_ready_in = 1'b1;
    next_cycle();
    fpu_req_ready_in = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if (busy_out !== 1'b1) begin
      miscompares++;
      $display("FAIL midwait_busy: got %b want 1", busy_out);
    end
    @(posedge clk);
    #2;
    apply_reset();
    do_op(2'b11, -1, 0, 0, 5'b00001, M_NORMAL, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int r;
    int mode;
    for (int n = 0; n < 40; n++) begin
      r    = $urandom_range(0, 9);
      mode = (r <= 4) ? M_NORMAL : (r == 5) ? M_FLUSH_ISSUE : (r <= 7) ? M_FLUSH_WAIT :
             (r == 8) ? M_FLUSH_SAME : M_NORMAL;
      if (mode != M_FLUSH_ISSUE && $urandom_range(0, 4) == 0) begin
        csr_at_wb       = 1'b1;
        csr_wdata_at_wb = 5'($urandom());
      end
      do_op(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), -1, $urandom_range(0, 3),
            $urandom_range(0, 5), 5'($urandom()), mode, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        flush_in = 1'($urandom_range(0, 1));
        next_cycle();
        flush_in = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #3;
    test_reset();
    test_single_op();
    test_fairness();
    test_flush();
    test_csr_write();
    test_watchdog();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
